timer_regs: RTL and testbench

- APB3 slave register bank that sits directly upstream of `timer`. It drives `timer`'s control inputs: `cmp_value`, `start_timer`, `timer_en`, `interrupt_en` and `auto_reload`.
- It consumes `timer`'s `done`, `irq` and `counter` outputs and presents a sticky pending flag plus a level interrupt to the CPU.
- It provides an atomic 64-bit compare update and a tear-free 64-bit counter read over a 32-bit bus.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_regs.sv | 135 +++++++++++++
 tb/tb_timer_regs.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer and its APB register bank: register offsets,
// CTRL/STATUS bit positions and the counter width common to both blocks.
package timer_pkg;

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned DATA_W = 32;

  // Byte offsets of the register map
  localparam int unsigned CTRL_OFS   = 'h00;
  localparam int unsigned STATUS_OFS = 'h04;
  localparam int unsigned CMP_LO_OFS = 'h08;
  localparam int unsigned CMP_HI_OFS = 'h0C;
  localparam int unsigned CNT_LO_OFS = 'h10;
  localparam int unsigned CNT_HI_OFS = 'h14;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_IE_BIT    = 1;
  localparam int unsigned CTRL_AR_BIT    = 2;
  localparam int unsigned CTRL_START_BIT = 3;

  // STATUS bit positions
  localparam int unsigned STAT_PEND_BIT = 0;
  localparam int unsigned STAT_IRQ_BIT  = 1;

endpackage

// File: rtl/timer_regs.sv
// APB3 register bank in front of the timer. Holds control bits, an atomic
// 64-bit compare value, a sticky pending flag with level interrupt, and a
// snapshot register for tear-free 64-bit counter reads.
//
// Ports:
//   clk, rst          - clock, async active-low reset
//   psel..pwdata      - APB3 request; prdata/pready/pslverr response
//   cmp_value         - 64-bit compare value to the timer
//   start_timer       - one-cycle start pulse
//   timer_en, interrupt_en, auto_reload - timer control levels
//   done, irq, counter - status from the timer
//   irq_out           - CPU interrupt (pending & interrupt_en), registered
module timer_regs
  import timer_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 5,
  parameter logic [CNT_W-1:0]      CMP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CNT_W-1:0]  cmp_value,
  output logic              start_timer,
  output logic              timer_en,
  output logic              interrupt_en,
  output logic              auto_reload,
  input  logic              done,
  input  logic              irq,
  input  logic [CNT_W-1:0]  counter,
  output logic              irq_out
);

  localparam int unsigned HI_W = CNT_W - DATA_W;

  logic [CNT_W-1:0]  r_cmp_value;
  logic [DATA_W-1:0] r_cmp_lo_shadow;
  logic [HI_W-1:0]   r_cnt_hi_snap;
  logic              r_timer_en;
  logic              r_interrupt_en;
  logic              r_auto_reload;
  logic              r_start_timer;
  logic              r_pending;
  logic              r_irq_out;

  logic w_access;
  logic w_sel_ctrl, w_sel_status, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_cnt_lo, w_sel_cnt_hi;
  logic w_mapped, w_misaligned, w_err;
  logic w_wr, w_rd;
  logic w_pending_next, w_ie_next;

  // Address decode and error classification
  assign w_access     = psel & penable;
  assign w_sel_ctrl   = (paddr == ADDR_W'(CTRL_OFS));
  assign w_sel_status = (paddr == ADDR_W'(STATUS_OFS));
  assign w_sel_cmp_lo = (paddr == ADDR_W'(CMP_LO_OFS));
  assign w_sel_cmp_hi = (paddr == ADDR_W'(CMP_HI_OFS));
  assign w_sel_cnt_lo = (paddr == ADDR_W'(CNT_LO_OFS));
  assign w_sel_cnt_hi = (paddr == ADDR_W'(CNT_HI_OFS));
  assign w_mapped     = w_sel_ctrl | w_sel_status | w_sel_cmp_lo | w_sel_cmp_hi
                      | w_sel_cnt_lo | w_sel_cnt_hi;
  assign w_misaligned = |paddr[1:0];
  assign w_err        = w_access & (w_misaligned | ~w_mapped
                                    | (pwrite & (w_sel_cnt_lo | w_sel_cnt_hi)));
  assign w_wr         = w_access & pwrite & ~w_err;
  assign w_rd         = w_access & ~pwrite & ~w_err;

  // A done in the same cycle as a clear wins, so the event is never lost
  assign w_pending_next = done | (r_pending & ~(w_wr & w_sel_status & pwdata[STAT_PEND_BIT]));
  assign w_ie_next      = (w_wr & w_sel_ctrl) ? pwdata[CTRL_IE_BIT] : r_interrupt_en;

  // Read mux: zero outside a successful read access
  always_comb begin
    prdata = '0;
    if (w_rd) begin
      if (w_sel_ctrl) begin
        prdata[CTRL_EN_BIT] = r_timer_en;
        prdata[CTRL_IE_BIT] = r_interrupt_en;
        prdata[CTRL_AR_BIT] = r_auto_reload;
      end
      if (w_sel_status) begin
        prdata[STAT_PEND_BIT] = r_pending;
        prdata[STAT_IRQ_BIT]  = irq;
      end
      if (w_sel_cmp_lo) prdata = r_cmp_value[DATA_W-1:0];
      if (w_sel_cmp_hi) prdata = DATA_W'(r_cmp_value[CNT_W-1:DATA_W]);
      if (w_sel_cnt_lo) prdata = counter[DATA_W-1:0];
      if (w_sel_cnt_hi) prdata = DATA_W'(r_cnt_hi_snap);
    end
  end

  // Register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp_value     <= CMP_RESET;
      r_cmp_lo_shadow <= '0;
      r_cnt_hi_snap   <= '0;
      r_timer_en      <= 1'b0;
      r_interrupt_en  <= 1'b0;
      r_auto_reload   <= 1'b0;
      r_start_timer   <= 1'b0;
      r_pending       <= 1'b0;
      r_irq_out       <= 1'b0;
    end else begin
      r_start_timer <= w_wr & w_sel_ctrl & pwdata[CTRL_START_BIT];
      if (w_wr & w_sel_ctrl) begin
        r_timer_en     <= pwdata[CTRL_EN_BIT];
        r_interrupt_en <= pwdata[CTRL_IE_BIT];
        r_auto_reload  <= pwdata[CTRL_AR_BIT];
      end
      if (w_wr & w_sel_cmp_lo) r_cmp_lo_shadow <= pwdata;
      // Both halves land on one edge so the timer never sees a torn compare
      if (w_wr & w_sel_cmp_hi) r_cmp_value <= {HI_W'(pwdata), r_cmp_lo_shadow};
      if (w_rd & w_sel_cnt_lo) r_cnt_hi_snap <= counter[CNT_W-1:DATA_W];
      r_pending <= w_pending_next;
      r_irq_out <= w_pending_next & w_ie_next;
    end
  end

  assign pready       = 1'b1;
  assign pslverr      = w_err;
  assign cmp_value    = r_cmp_value;
  assign start_timer  = r_start_timer;
  assign timer_en     = r_timer_en;
  assign interrupt_en = r_interrupt_en;
  assign auto_reload  = r_auto_reload;
  assign irq_out      = r_irq_out;

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: directed scenarios followed by random
// APB traffic, checked against a behavioural register-map model.
module tb_timer_regs;

  localparam logic [63:0] TB_CMP_RESET = 64'hDEAD_BEEF_0000_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [63:0] cmp_value;
  logic        start_timer, timer_en, interrupt_en, auto_reload;
  logic        done, irq;
  logic [63:0] counter;
  logic        irq_out;

  timer_regs #(.ADDR_W(5), .CMP_RESET(TB_CMP_RESET)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cmp_value(cmp_value), .start_timer(start_timer),
    .timer_en(timer_en), .interrupt_en(interrupt_en), .auto_reload(auto_reload),
    .done(done), .irq(irq), .counter(counter), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_en, m_ie, m_ar, m_start, m_pend, m_irq_out;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow, m_snap;

  // Inputs held by the wrappers
  bit          g_done, g_irq;
  logic [63:0] g_cnt;
  logic [31:0] g_last_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_ar = 0; m_start = 0; m_pend = 0; m_irq_out = 0;
    m_cmp = TB_CMP_RESET; m_shadow = '0; m_snap = '0;
  endtask

  function automatic bit is_legal(input logic [4:0] a);
    return a inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
  endfunction

  // One clock cycle: drive at negedge, check combinational response, then
  // advance the model on the edge and check registered outputs.
  task automatic step(input bit sel, input bit en, input bit wr, input logic [4:0] a,
                      input logic [31:0] d, input bit dn, input bit iq, input logic [63:0] cnt);
    bit          acc, err, clr;
    logic [31:0] exp_rd;
    psel = sel; penable = en; pwrite = wr; paddr = a; pwdata = d;
    done = dn; irq = iq; counter = cnt;
    #1;
    acc = sel && en;
    err = acc && (!is_legal(a) || (wr && a >= 5'h10));
    exp_rd = '0;
    if (acc && !wr && !err) begin
      case (a)
        5'h00:   exp_rd = {29'd0, m_ar, m_ie, m_en};
        5'h04:   exp_rd = {30'd0, iq, m_pend};
        5'h08:   exp_rd = m_cmp[31:0];
        5'h0C:   exp_rd = m_cmp[63:32];
        5'h10:   exp_rd = cnt[31:0];
        default: exp_rd = m_snap;
      endcase
    end
    if (acc) g_last_rd = prdata;
    check_eq("prdata", prdata, exp_rd);
    check_eq("pslverr", pslverr, err);
    @(posedge clk);
    clr = 0;
    m_start = 0;
    if (acc && !err && wr) begin
      case (a)
        5'h00: begin m_en = d[0]; m_ie = d[1]; m_ar = d[2]; m_start = d[3]; end
        5'h04: clr = d[0];
        5'h08: m_shadow = d;
        default: m_cmp = {d, m_shadow};
      endcase
    end
    if (acc && !err && !wr && a == 5'h10) m_snap = cnt[63:32];
    m_pend = dn || (m_pend && !clr);
    m_irq_out = m_pend && m_ie;
    @(negedge clk);
    check_eq("cmp_value", cmp_value, m_cmp);
    check_eq("ctrl_bits", {auto_reload, interrupt_en, timer_en}, {m_ar, m_ie, m_en});
    check_eq("start_timer", start_timer, m_start);
    check_eq("irq_out", irq_out, m_irq_out);
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    step(1, 0, 1, a, d, g_done, g_irq, g_cnt);
    step(1, 1, 1, a, d, g_done, g_irq, g_cnt);
  endtask

  task automatic apb_rd(input logic [4:0] a);
    step(1, 0, 0, a, '0, g_done, g_irq, g_cnt);
    step(1, 1, 0, a, '0, g_done, g_irq, g_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, g_done, g_irq, g_cnt);
  endtask

  logic [4:0] addr_tab [10] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14,
                                5'h18, 5'h02, 5'h1C, 5'h05};

  initial begin
    rst = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    done = 0; irq = 0; counter = '0;
    g_done = 0; g_irq = 0; g_cnt = '0; g_last_rd = '0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cmp", cmp_value, TB_CMP_RESET);
    check_eq("rst_ctrl", {start_timer, auto_reload, interrupt_en, timer_en}, 4'd0);
    check_eq("rst_irq_out", irq_out, 1'b0);
    check_eq("rst_pready", pready, 1'b1);
    rst = 1'b1;
    apb_rd(5'h00);
    check_eq("ctrl_read_rst", g_last_rd, 32'd0);

    // Atomic compare update
    apb_wr(5'h08, 32'h19);
    check_eq("cmp_after_lo", cmp_value, TB_CMP_RESET);
    apb_wr(5'h0C, 32'h0);
    check_eq("cmp_after_hi", cmp_value, 64'd25);

    // CTRL with START: single-cycle pulse
    apb_wr(5'h00, 32'hF);
    check_eq("start_pulse", start_timer, 1'b1);
    idle(1);
    check_eq("start_gone", start_timer, 1'b0);

    // done sets pending, irq_out one cycle later
    g_done = 1; idle(1); g_done = 0;
    check_eq("irq_after_done", irq_out, 1'b1);
    idle(2);

    // Tear-free counter snapshot across a 32-bit carry
    g_cnt = 64'h0000_0000_FFFF_FFFF;
    apb_rd(5'h10);
    check_eq("cnt_lo", g_last_rd, 32'hFFFF_FFFF);
    g_cnt = 64'h0000_0001_0000_0000;
    apb_rd(5'h14);
    check_eq("cnt_hi_snap", g_last_rd, 32'h0);

    // Set wins over clear
    g_done = 1;
    apb_wr(5'h04, 32'h1);
    g_done = 0;
    apb_rd(5'h04);
    check_eq("pend_set_wins", g_last_rd[0], 1'b1);
    apb_wr(5'h04, 32'h1);
    check_eq("pend_cleared_irq", irq_out, 1'b0);
    apb_rd(5'h04);
    check_eq("pend_cleared", g_last_rd[0], 1'b0);

    // CTRL 0 then 9
    apb_wr(5'h00, 32'h0);
    check_eq("en_dropped", timer_en, 1'b0);
    apb_wr(5'h00, 32'h9);
    check_eq("restart", {start_timer, auto_reload, interrupt_en, timer_en}, 4'b1001);
    idle(1);

    // Error transfers change nothing, including the snapshot
    g_cnt = 64'h1234_5678_9ABC_DEF0;
    apb_wr(5'h10, 32'hFFFF_FFFF);
    apb_rd(5'h18);
    apb_rd(5'h02);
    apb_wr(5'h02, 32'hF);
    apb_rd(5'h14);
    check_eq("snap_unchanged", g_last_rd, 32'h0);

    // Reset mid-transfer aborts the write
    psel = 1; penable = 1; pwrite = 1; paddr = 5'h00; pwdata = 32'h6;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_ctrl", {auto_reload, interrupt_en, timer_en}, 3'd0);
    check_eq("rst_mid_cmp", cmp_value, TB_CMP_RESET);
    psel = 0; penable = 0;
    rst = 1'b1;
    model_reset();

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      logic [4:0] a;
      a = addr_tab[$urandom_range(0, 9)];
      g_done = ($urandom_range(0, 7) == 0);
      g_irq  = $urandom_range(0, 1) == 1;
      g_cnt  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) apb_wr(a, $urandom);
      else apb_rd(a);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    g_done = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
